cam_axis_framer: RTL and testbench

Parametrised single-clock CameraLink-to-AXI4-Stream video framer. It takes already-parsed, already-synchronised CameraLink taps (FVAL/LVAL/DVAL plus TAPS×8-bit pixel ports) and emits an AXI4-Stream video stream: tuser marks start of frame, tlast marks end of line. It sits after the tap parser and any clock-domain crossing, and replaces the fixed 3-tap, free-running input path with buffered, frame-resynchronising output. Line and frame statistics are kept, and FIFO overflow terminates the frame cleanly.

---
 rtl/cam_axis_pkg.sv | 26 ++
 rtl/cam_axis_framer_if.sv | 13 +
 rtl/cam_axis_sfifo.sv | 51 +++++
 rtl/cam_axis_framer.sv | 199 +++++++++++++++++++
 tb/tb_cam_axis_framer.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_axis_pkg.sv
// Shared constants for the CameraLink-to-AXI4-Stream framer:
// FSM encoding, tap byte width and FIFO entry field offsets.
package cam_axis_pkg;

  localparam int TAP_W = 8;

  localparam logic [1:0] ST_WAIT_SOF = 2'd0;
  localparam logic [1:0] ST_ACTIVE   = 2'd1;
  localparam logic [1:0] ST_DROP     = 2'd2;

  // FIFO entry layout, MSB first: {user, last, data}
  localparam int ENT_DATA = 0;

  function automatic int ent_last(input int taps);
    return taps * TAP_W;
  endfunction

  function automatic int ent_user(input int taps);
    return taps * TAP_W + 1;
  endfunction

  function automatic int ent_width(input int taps);
    return taps * TAP_W + 2;
  endfunction

endpackage

// File: rtl/cam_axis_framer_if.sv
// AXI4-Stream video output bundle: tuser marks start of frame, tlast end of line.
interface cam_axis_framer_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/cam_axis_sfifo.sv
// Synchronous first-word-fall-through FIFO; read data reads as zero while empty.
module cam_axis_sfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cam_axis_framer.sv
// CameraLink taps to AXI4-Stream framer with hold register, FWFT output buffer and stats.
// state    | meaning
// WAIT_SOF | discard input until FVAL rises
// ACTIVE   | hold-and-write pixels, flush on line/frame end
// DROP     | frame truncated by overflow, discard until FVAL low
module cam_axis_framer
  import cam_axis_pkg::*;
#(
  parameter int TAPS       = 3,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 axis_clk,
  input  logic                 aresetn,
  input  logic                 cam_fval,
  input  logic                 cam_lval,
  input  logic                 cam_dval,
  input  logic [TAPS*TAP_W-1:0] cam_data,
  cam_axis_framer_if.master    m_axis,
  input  logic                 stat_clear,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] line_width,
  output logic [CNT_WIDTH-1:0] frame_lines
);
  localparam int DW       = TAPS * TAP_W;
  localparam int EW       = ent_width(TAPS);
  localparam int LAST_BIT = ent_last(TAPS);
  localparam int USER_BIT = ent_user(TAPS);
  localparam int CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]        LAST_FREE = CW'(FIFO_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  logic          fval_s1, lval_s1, dval_s1;
  logic          fval_d, lval_d;
  logic [DW-1:0] data_s1;
  logic          fval_rise, fval_fall, lval_fall, pixel;

  logic [1:0]    state;
  logic          hold_valid;
  logic [DW-1:0] hold_data;
  logic          first_pending;

  logic          wr_en, wr_last, ovf_hit, sof_start, frame_done;
  logic [EW-1:0] wr_entry, rd_entry;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

  logic [CNT_WIDTH-1:0] line_cnt, frame_line_cnt, lines_inc, lines_next;

  // FVAL history resets high so a frame already running at reset release is not seen as a rise
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      fval_s1 <= 1'b1;
      fval_d  <= 1'b1;
      lval_s1 <= 1'b0;
      lval_d  <= 1'b0;
      dval_s1 <= 1'b0;
      data_s1 <= '0;
    end else begin
      fval_s1 <= cam_fval;
      lval_s1 <= cam_lval;
      dval_s1 <= cam_dval;
      data_s1 <= cam_data;
      fval_d  <= fval_s1;
      lval_d  <= lval_s1;
    end
  end

  assign fval_rise  = fval_s1 & ~fval_d;
  assign fval_fall  = ~fval_s1 & fval_d;
  assign lval_fall  = ~lval_s1 & lval_d;
  assign pixel      = dval_s1 & lval_s1 & fval_s1;
  assign sof_start  = (state == ST_WAIT_SOF) && fval_rise;
  assign frame_done = (state == ST_ACTIVE) && fval_fall && !ovf_hit;

  always_comb begin
    wr_en   = 1'b0;
    wr_last = 1'b0;
    ovf_hit = 1'b0;
    if (state == ST_ACTIVE && hold_valid) begin
      if (pixel) begin
        wr_en = 1'b1;
      end else if (lval_fall || fval_fall) begin
        wr_en   = 1'b1;
        wr_last = 1'b1;
      end
    end
    // the last free slot closes the line and truncates the frame
    if (wr_en && fifo_count == LAST_FREE) begin
      ovf_hit = 1'b1;
      wr_last = 1'b1;
    end
  end

  always_comb begin
    wr_entry                 = '0;
    wr_entry[ENT_DATA +: DW] = hold_data;
    wr_entry[LAST_BIT]       = wr_last;
    wr_entry[USER_BIT]       = first_pending;
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= ST_WAIT_SOF;
      hold_valid    <= 1'b0;
      hold_data     <= '0;
      first_pending <= 1'b0;
    end else begin
      case (state)
        ST_WAIT_SOF: begin
          if (fval_rise) begin
            state         <= ST_ACTIVE;
            first_pending <= 1'b1;
            hold_valid    <= pixel;
            hold_data     <= data_s1;
          end
        end
        ST_ACTIVE: begin
          if (wr_en) first_pending <= 1'b0;
          if (ovf_hit) begin
            state      <= ST_DROP;
            hold_valid <= 1'b0;
          end else if (pixel) begin
            hold_valid <= 1'b1;
            hold_data  <= data_s1;
          end else if (lval_fall || fval_fall) begin
            hold_valid <= 1'b0;
          end
          if (frame_done) state <= ST_WAIT_SOF;
        end
        ST_DROP: begin
          if (!fval_s1) state <= ST_WAIT_SOF;
        end
        default: state <= ST_WAIT_SOF;
      endcase
    end
  end

  cam_axis_sfifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (axis_clk),
    .rst_n   (aresetn),
    .wr_en   (wr_en & ~fifo_full),
    .wr_data (wr_entry),
    .rd_en   (m_axis.tvalid & m_axis.tready),
    .rd_data (rd_entry),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_axis.tvalid = ~fifo_empty;
  assign m_axis.tdata  = rd_entry[ENT_DATA +: DW];
  assign m_axis.tlast  = rd_entry[LAST_BIT];
  assign m_axis.tuser  = rd_entry[USER_BIT];

  assign lines_inc  = sat_inc(frame_line_cnt);
  assign lines_next = (wr_en && wr_last) ? lines_inc : frame_line_cnt;

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      line_cnt       <= '0;
      frame_line_cnt <= '0;
      line_width     <= '0;
      frame_lines    <= '0;
      frame_count    <= '0;
      overflow       <= 1'b0;
    end else begin
      if (sof_start) begin
        line_cnt       <= '0;
        frame_line_cnt <= '0;
      end else if (wr_en) begin
        if (wr_last) begin
          line_width     <= sat_inc(line_cnt);
          line_cnt       <= '0;
          frame_line_cnt <= lines_inc;
        end else begin
          line_cnt <= sat_inc(line_cnt);
        end
      end
      if (frame_done) begin
        frame_lines    <= lines_next;
        frame_line_cnt <= '0;
      end
      if (stat_clear)      frame_count <= '0;
      else if (frame_done) frame_count <= sat_inc(frame_count);
      if (ovf_hit)         overflow <= 1'b1;
      else if (stat_clear) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cam_axis_framer.sv
// Self-checking bench for cam_axis_framer: two instances (64- and 8-entry buffers) on shared camera inputs.
module tb_cam_axis_framer;
  localparam int DW = 24;
  localparam int CW = 16;

  logic          axis_clk = 1'b0;
  logic          aresetn  = 1'b0;
  logic          cam_fval = 1'b0;
  logic          cam_lval = 1'b0;
  logic          cam_dval = 1'b0;
  logic [DW-1:0] cam_data = '0;
  logic          stat_clear = 1'b0;

  logic          overflow_a, overflow_b;
  logic [CW-1:0] frame_count_a, line_width_a, frame_lines_a;
  logic [CW-1:0] frame_count_b, line_width_b, frame_lines_b;

  cam_axis_framer_if #(.DATA_W(DW)) axis_a ();
  cam_axis_framer_if #(.DATA_W(DW)) axis_b ();

  cam_axis_framer #(.TAPS(3), .FIFO_DEPTH(64), .CNT_WIDTH(CW)) dut (
    .axis_clk (axis_clk), .aresetn (aresetn),
    .cam_fval (cam_fval), .cam_lval (cam_lval), .cam_dval (cam_dval), .cam_data (cam_data),
    .m_axis (axis_a), .stat_clear (stat_clear), .overflow (overflow_a),
    .frame_count (frame_count_a), .line_width (line_width_a), .frame_lines (frame_lines_a)
  );

  cam_axis_framer #(.TAPS(3), .FIFO_DEPTH(8), .CNT_WIDTH(CW)) dut8 (
    .axis_clk (axis_clk), .aresetn (aresetn),
    .cam_fval (cam_fval), .cam_lval (cam_lval), .cam_dval (cam_dval), .cam_data (cam_data),
    .m_axis (axis_b), .stat_clear (stat_clear), .overflow (overflow_b),
    .frame_count (frame_count_b), .line_width (line_width_b), .frame_lines (frame_lines_b)
  );

  always #5 axis_clk = ~axis_clk;

  int checks = 0;
  int errors = 0;
  int exp_fc_a = 0;
  int exp_fc_b = 0;
  int pix_k = 0;
  bit use_pattern = 1'b1;

  // beats are {user, last, data}
  logic [DW+1:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
  logic [DW+1:0] beat_a, beat_b, held_a, held_b;
  bit stall_a = 1'b0;
  bit stall_b = 1'b0;

  assign beat_a = {axis_a.tuser, axis_a.tlast, axis_a.tdata};
  assign beat_b = {axis_b.tuser, axis_b.tlast, axis_b.tdata};

  always @(negedge axis_clk) begin
    if (!aresetn) begin
      stall_a = 1'b0;
      stall_b = 1'b0;
    end else begin
      if (stall_a) begin
        checks++;
        if (!axis_a.tvalid || beat_a !== held_a) begin
          errors++;
          $display("FAIL stall_hold_a got %h exp %h", beat_a, held_a);
        end
      end
      if (stall_b) begin
        checks++;
        if (!axis_b.tvalid || beat_b !== held_b) begin
          errors++;
          $display("FAIL stall_hold_b got %h exp %h", beat_b, held_b);
        end
      end
      if (axis_a.tvalid && axis_a.tready) got_a.push_back(beat_a);
      if (axis_b.tvalid && axis_b.tready) got_b.push_back(beat_b);
      stall_a = axis_a.tvalid && !axis_a.tready;
      stall_b = axis_b.tvalid && !axis_b.tready;
      held_a  = beat_a;
      held_b  = beat_b;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge axis_clk);
      #1;
    end
  endtask

  function automatic logic [DW-1:0] pattern(input int k);
    logic [7:0] b0, b1, b2;
    b0 = 8'(3 * k + 1);
    b1 = 8'(3 * k + 2);
    b2 = 8'(3 * k + 3);
    return {b0, b1, b2};
  endfunction

  task automatic drive_line(input int npix, input int gap_at, input int gap_len,
                            input bit sof, input bit push);
    logic [DW-1:0] v;
    logic [DW+1:0] e;
    cam_lval = 1'b1;
    for (int p = 0; p < npix; p++) begin
      if (p == gap_at) begin
        cam_dval = 1'b0;
        tick(gap_len);
      end
      v = use_pattern ? pattern(pix_k) : DW'($urandom);
      pix_k++;
      cam_dval = 1'b1;
      cam_data = v;
      tick(1);
      if (push) begin
        e = {sof && (p == 0), p == npix - 1, v};
        exp_a.push_back(e);
        exp_b.push_back(e);
      end
    end
    cam_dval = 1'b0;
    cam_lval = 1'b0;
    tick(3);
  endtask

  // clr pulses stat_clear on the edge where the frame end is counted
  task automatic send_frame(input int nlines, input int ppl, input int gap_at,
                            input int gap_len, input bit clr);
    cam_fval = 1'b1;
    tick(2);
    for (int l = 0; l < nlines; l++) drive_line(ppl, gap_at, gap_len, l == 0, 1'b1);
    cam_fval = 1'b0;
    tick(1);
    if (clr) stat_clear = 1'b1;
    tick(1);
    stat_clear = 1'b0;
    tick(2);
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got_a.size() >= exp_a.size() && got_b.size() >= exp_b.size()) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    tick(10);
  endtask

  task automatic clear_queues();
    got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    tick(3);
    checks++;
    if ({axis_a.tvalid, axis_a.tlast, axis_a.tuser} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {axis_a.tvalid, axis_a.tlast, axis_a.tuser});
    end
    checks++;
    if (axis_a.tdata !== '0) begin errors++; $display("FAIL reset_tdata got %h exp 0", axis_a.tdata); end
    checks++;
    if ({overflow_a, frame_count_a} !== '0) begin
      errors++; $display("FAIL reset_ovf_fc got %b/%0d exp 0/0", overflow_a, frame_count_a);
    end
    checks++;
    if ({line_width_a, frame_lines_a} !== '0) begin
      errors++; $display("FAIL reset_widths got %0d/%0d exp 0/0", line_width_a, frame_lines_a);
    end
  endtask

  task automatic test_mid_frame_start();
    clear_queues();
    use_pattern = 1'b0;
    cam_fval = 1'b1;
    tick(2);
    aresetn = 1'b1;
    tick(2);
    drive_line(5, -1, 0, 1'b0, 1'b0);
    drive_line(5, -1, 0, 1'b0, 1'b0);
    cam_fval = 1'b0;
    tick(6);
    checks++;
    if (got_a.size() != 0 || got_b.size() != 0) begin
      errors++; $display("FAIL midframe_output got %0d/%0d exp 0/0", got_a.size(), got_b.size());
    end
    checks++;
    if (frame_count_a !== '0 || line_width_a !== '0) begin
      errors++; $display("FAIL midframe_stats got %0d/%0d exp 0/0", frame_count_a, line_width_a);
    end
  endtask

  task automatic test_nominal();
    bit ok;
    clear_queues();
    use_pattern = 1'b1;
    pix_k = 0;
    send_frame(2, 4, -1, 0, 1'b0);
    exp_fc_a++; exp_fc_b++;
    wait_drain(200, ok);
    checks++;
    if (!ok || got_a.size() != exp_a.size()) begin
      errors++; $display("FAIL nominal_count got %0d exp %0d", got_a.size(), exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== exp_a[i]) begin
        errors++; $display("FAIL nominal_beat%0d got %h exp %h", i, got_a[i], exp_a[i]);
      end
    end
    checks++;
    if (line_width_a !== CW'(4) || frame_lines_a !== CW'(2) || frame_count_a !== CW'(exp_fc_a)) begin
      errors++; $display("FAIL nominal_stats got %0d/%0d/%0d exp 4/2/%0d",
                         line_width_a, frame_lines_a, frame_count_a, exp_fc_a);
    end
  endtask

  task automatic test_dval_gaps();
    bit ok;
    clear_queues();
    use_pattern = 1'b0;
    send_frame(1, 6, 2, 3, 1'b0);
    exp_fc_a++; exp_fc_b++;
    wait_drain(200, ok);
    checks++;
    if (!ok || got_a.size() != 6) begin
      errors++; $display("FAIL gaps_count got %0d exp 6", got_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== exp_a[i]) begin
        errors++; $display("FAIL gaps_beat%0d got %h exp %h", i, got_a[i], exp_a[i]);
      end
    end
    checks++;
    if (line_width_a !== CW'(6) || frame_lines_a !== CW'(1) || frame_count_a !== CW'(exp_fc_a)) begin
      errors++; $display("FAIL gaps_stats got %0d/%0d/%0d exp 6/1/%0d",
                         line_width_a, frame_lines_a, frame_count_a, exp_fc_a);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [DW+1:0] t;
    clear_queues();
    use_pattern = 1'b0;
    axis_b.tready = 1'b0;
    send_frame(1, 20, -1, 0, 1'b0);
    exp_fc_a++;
    checks++;
    if (overflow_b !== 1'b1 || overflow_a !== 1'b0) begin
      errors++; $display("FAIL ovf_flags got %b/%b exp 1/0", overflow_b, overflow_a);
    end
    checks++;
    if (line_width_b !== CW'(8) || frame_count_b !== CW'(exp_fc_b)) begin
      errors++; $display("FAIL ovf_stats got %0d/%0d exp 8/%0d", line_width_b, frame_count_b, exp_fc_b);
    end
    // the 8-entry buffer keeps the first 8 pixels with the last one closing the line
    while (exp_b.size() > 8) void'(exp_b.pop_back());
    t = exp_b[7];
    t[DW] = 1'b1;
    exp_b[7] = t;
    axis_b.tready = 1'b1;
    wait_drain(300, ok);
    checks++;
    if (!ok || got_b.size() != 8 || got_a.size() != 20) begin
      errors++; $display("FAIL ovf_count got %0d/%0d exp 8/20", got_b.size(), got_a.size());
    end
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      checks++;
      if (got_b[i] !== exp_b[i]) begin
        errors++; $display("FAIL ovf_beat%0d got %h exp %h", i, got_b[i], exp_b[i]);
      end
    end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== exp_a[i]) begin
        errors++; $display("FAIL ovf_ref_beat%0d got %h exp %h", i, got_a[i], exp_a[i]);
      end
    end
    clear_queues();
    send_frame(1, 3, -1, 0, 1'b0);
    exp_fc_a++; exp_fc_b++;
    wait_drain(200, ok);
    checks++;
    if (!ok || got_b.size() != 3) begin
      errors++; $display("FAIL recover_count got %0d exp 3", got_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      checks++;
      if (got_b[i] !== exp_b[i]) begin
        errors++; $display("FAIL recover_beat%0d got %h exp %h", i, got_b[i], exp_b[i]);
      end
    end
    checks++;
    if (frame_count_b !== CW'(exp_fc_b) || overflow_b !== 1'b1) begin
      errors++; $display("FAIL recover_stats got %0d/%b exp %0d/1", frame_count_b, overflow_b, exp_fc_b);
    end
  endtask

  task automatic test_backpressure();
    bit done;
    clear_queues();
    use_pattern = 1'b0;
    done = 1'b0;
    fork
      begin
        send_frame(2, 16, -1, 0, 1'b0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          tick(1);
          axis_a.tready = 1'($urandom_range(0, 1));
        end
      end
    join
    exp_fc_a++; exp_fc_b++;
    for (int i = 0; i < 2000 && got_a.size() < exp_a.size(); i++) begin
      tick(1);
      axis_a.tready = 1'($urandom_range(0, 1));
    end
    axis_a.tready = 1'b1;
    tick(10);
    checks++;
    if (got_a.size() != 32) begin
      errors++; $display("FAIL bp_count got %0d exp 32", got_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== exp_a[i]) begin
        errors++; $display("FAIL bp_beat%0d got %h exp %h", i, got_a[i], exp_a[i]);
      end
    end
    checks++;
    if (overflow_a !== 1'b0 || line_width_a !== CW'(16) || frame_lines_a !== CW'(2)
        || frame_count_a !== CW'(exp_fc_a)) begin
      errors++; $display("FAIL bp_stats got %b/%0d/%0d/%0d exp 0/16/2/%0d",
                         overflow_a, line_width_a, frame_lines_a, frame_count_a, exp_fc_a);
    end
  endtask

  task automatic test_reset_stat_clear();
    bit ok;
    clear_queues();
    use_pattern = 1'b0;
    axis_a.tready = 1'b0;
    cam_fval = 1'b1;
    tick(2);
    cam_lval = 1'b1;
    for (int p = 0; p < 5; p++) begin
      cam_dval = 1'b1;
      cam_data = DW'($urandom);
      tick(1);
    end
    checks++;
    if (axis_a.tvalid !== 1'b1) begin
      errors++; $display("FAIL prereset_valid got %b exp 1", axis_a.tvalid);
    end
    @(posedge axis_clk);
    #3;
    aresetn = 1'b0;
    #1;
    checks++;
    if ({axis_a.tvalid, axis_a.tlast, axis_a.tuser} !== 3'b000 || axis_a.tdata !== '0) begin
      errors++; $display("FAIL async_reset_axis got %b/%h exp 000/0",
                         {axis_a.tvalid, axis_a.tlast, axis_a.tuser}, axis_a.tdata);
    end
    checks++;
    if (overflow_b !== 1'b0 || frame_count_a !== '0 || line_width_a !== '0 || frame_lines_a !== '0) begin
      errors++; $display("FAIL async_reset_stats got %b/%0d/%0d/%0d exp 0/0/0/0",
                         overflow_b, frame_count_a, line_width_a, frame_lines_a);
    end
    exp_fc_a = 0;
    exp_fc_b = 0;
    tick(2);
    aresetn = 1'b1;
    axis_a.tready = 1'b1;
    tick(3);
    cam_dval = 1'b0;
    cam_lval = 1'b0;
    tick(3);
    cam_fval = 1'b0;
    tick(5);
    checks++;
    if (got_a.size() != 0) begin
      errors++; $display("FAIL postreset_output got %0d exp 0", got_a.size());
    end
    send_frame(2, 5, -1, 0, 1'b1);
    wait_drain(200, ok);
    checks++;
    if (!ok || got_a.size() != 10) begin
      errors++; $display("FAIL clr_count got %0d exp 10", got_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== exp_a[i]) begin
        errors++; $display("FAIL clr_beat%0d got %h exp %h", i, got_a[i], exp_a[i]);
      end
    end
    checks++;
    if (frame_count_a !== CW'(exp_fc_a) || frame_count_b !== CW'(exp_fc_b)
        || line_width_a !== CW'(5) || frame_lines_a !== CW'(2)) begin
      errors++; $display("FAIL clr_stats got %0d/%0d/%0d/%0d exp 0/0/5/2",
                         frame_count_a, frame_count_b, line_width_a, frame_lines_a);
    end
  endtask

  initial begin
    axis_a.tready = 1'b1;
    axis_b.tready = 1'b1;
    test_reset();
    test_mid_frame_start();
    test_nominal();
    test_dval_gaps();
    test_overflow();
    test_backpressure();
    test_reset_stat_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
